// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the multicycle restoring divider.
//   div_state_t : FSM encoding (IDLE, RUN, FIX)
//   DIV_WIDTH   : default operand width
//   DIV_CNT_W   : iteration-counter width for the default operand width
//   div_cnt_w() : counter width as a function of an arbitrary operand width
//   div_abs()   : conditional two's-complement negate on a wide word. Callers
//                 zero-extend into div_word_t and truncate the result back, so
//                 any operand width up to DIV_MAX_W bits is supported.
// ----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_MAX_W = 128;

    typedef logic [DIV_MAX_W-1:0] div_word_t;

    function automatic int div_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

    // Negation modulo 2^DIV_MAX_W; truncating the result to a narrower width
    // yields the correct negation modulo that width.
    function automatic div_word_t div_abs(input div_word_t value, input logic negate);
        return negate ? (~value + div_word_t'(1)) : value;
    endfunction

endpackage

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder
// Single full-adder bit cell with an add/subtract control. With i_sub=1 the
// b operand is inverted; chaining cells with carry-in 1 at bit 0 forms a - b.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   i_sub    : 1 = subtract (invert i_b)
//   o_sum    : sum bit
//   o_cout   : carry out (for subtraction, 1 = no borrow)
// ----------------------------------------------------------------------------
module adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    input  logic i_sub,
    output logic o_sum,
    output logic o_cout
);

    logic w_b;

    assign w_b    = i_b ^ i_sub;
    assign o_sum  = i_a ^ w_b ^ i_cin;
    assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The partial remainder is
// shifted left with the next dividend bit entering at the bottom, then the
// divisor is trial-subtracted over WIDTH+1 bits using a chain of adder cells.
//   i_prem    : current partial remainder (always < divisor)
//   i_divisor : divisor magnitude
//   i_bit     : next dividend bit (MSB first)
//   o_prem    : next partial remainder (trial result or restored value)
//   o_qbit    : quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_prem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_prem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_carry;
    logic             w_unused_cout;

    assign w_shift    = {i_prem, i_bit};
    assign w_dvs_ext  = {1'b0, i_divisor};
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g <= WIDTH; g++) begin : g_cell
        adder u_cell (
            .i_a    (w_shift[g]),
            .i_b    (w_dvs_ext[g]),
            .i_cin  (w_carry[g]),
            .i_sub  (1'b1),
            .o_sum  (w_diff[g]),
            .o_cout (w_carry[g+1])
        );
    end

    // The shifted remainder is below 2*divisor, so the difference always lies
    // in (-2^WIDTH, 2^WIDTH) and bit WIDTH is a true sign bit.
    assign w_unused_cout = w_carry[WIDTH+1];
    assign o_qbit        = ~w_diff[WIDTH];
    assign o_prem        = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
// Multicycle restoring integer divider (DIV/DIVU). One quotient bit per cycle
// on operand magnitudes, then a sign-fix cycle. Division by zero and the
// signed MIN / -1 overflow case skip the iteration and go straight to FIX.
// Remainder sign follows the dividend (truncating division).
//
// Optional feature macro: DIVIDER_FLUSH_EN adds the `flush` input, which
// aborts an in-flight divide without producing a result.
//
// Ports:
//   clock     : clock, rising edge
//   reset_n   : synchronous active-low reset
//   start     : request a divide, sampled only while ready=1
//   is_signed : 1 = two's-complement divide, 0 = unsigned
//   dividend  : numerator
//   divisor   : denominator
//   flush     : abort in-flight divide (DIVIDER_FLUSH_EN only)
//   ready     : idle, can accept start
//   valid     : one-cycle pulse, quotient/remainder just updated
//   quotient  : result, held until the next divide completes
//   remainder : result, held until the next divide completes
// ----------------------------------------------------------------------------
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_FLUSH_EN
    input  logic             flush,
`endif
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W   = div_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_fast;
    logic             r_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_flush;
    logic             w_ready;
    logic             w_accept;
    logic             w_run;
    logic             w_commit;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_quo;
    logic [WIDTH-1:0] w_fast_rem;

    logic [WIDTH-1:0] w_step_prem;
    logic             w_step_qbit;
    logic [WIDTH-1:0] w_quo_fixed;
    logic [WIDTH-1:0] w_rem_fixed;

`ifdef DIVIDER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Operand conditioning and fast-path detection (used only on accept)
    // ------------------------------------------------------------------------
    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_abs  = WIDTH'(div_abs(div_word_t'(dividend), w_dvd_neg));
    assign w_dvs_abs  = WIDTH'(div_abs(div_word_t'(divisor), w_dvs_neg));

    assign w_div_zero = (divisor == '0);
    assign w_overflow = is_signed & (dividend == MIN_VAL) & (&divisor);
    assign w_fast     = w_div_zero | w_overflow;

    // Divide-by-zero returns the raw dividend as remainder; overflow returns
    // MIN (which equals the dividend) with a zero remainder.
    assign w_fast_quo = w_div_zero ? '1 : dividend;
    assign w_fast_rem = w_div_zero ? dividend : '0;

    // ------------------------------------------------------------------------
    // Iteration datapath and sign correction
    // ------------------------------------------------------------------------
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_prem    (r_prem),
        .i_divisor (r_dvs),
        .i_bit     (r_quo[WIDTH-1]),
        .o_prem    (w_step_prem),
        .o_qbit    (w_step_qbit)
    );

    assign w_quo_fixed = WIDTH'(div_abs(div_word_t'(r_quo),  r_q_neg & ~r_fast));
    assign w_rem_fixed = WIDTH'(div_abs(div_word_t'(r_prem), r_r_neg & ~r_fast));

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start && !w_flush) begin
                    w_accept     = 1'b1;
                    w_next_state = w_fast ? FIX : RUN;
                end
            end
            RUN: begin
                if (w_flush) begin
                    w_next_state = IDLE;
                end else begin
                    w_run = 1'b1;
                    if (r_cnt == '0) begin
                        w_next_state = FIX;
                    end
                end
            end
            FIX: begin
                w_next_state = IDLE;
                w_commit     = !w_flush;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Working registers and results
    // ------------------------------------------------------------------------
    // NOTE: the datapath registers are reset along with the control so the
    // counter and outputs come up at defined values; none of them is a
    // memory array, so the reset costs nothing structurally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_fast      <= 1'b0;
            r_valid     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_valid <= w_commit;

            if (w_accept) begin
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_dvs   <= w_dvs_abs;
                r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                r_r_neg <= w_dvd_neg;
                r_fast  <= w_fast;
                // The quotient register starts out holding the dividend
                // magnitude; its bits shift out into the partial remainder as
                // quotient bits shift in at the bottom.
                r_prem  <= w_fast ? w_fast_rem : '0;
                r_quo   <= w_fast ? w_fast_quo : w_dvd_abs;
            end else if (w_run) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_prem <= w_step_prem;
                r_quo  <= {r_quo[WIDTH-2:0], w_step_qbit};
            end

            if (w_commit) begin
                r_quotient  <= w_quo_fixed;
                r_remainder <= w_rem_fixed;
            end
        end
    end

    assign ready     = w_ready;
    assign valid     = r_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_divider.sv
// ----------------------------------------------------------------------------
// tb_divider
// Directed self-checking bench for the 64-bit divider. Each divide checks
// latency to valid, ready low while busy, ready high with valid, the quotient
// and remainder, and that the previous results stay put until the new valid.
// Flush scenarios are compiled in when DIVIDER_FLUSH_EN is defined.
// ----------------------------------------------------------------------------
module tb_divider;

    localparam int W = 64;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         ready;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_cmp;
    int n_fail;

    divider #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIVIDER_FLUSH_EN
        .flush     (flush),
`endif
        .ready     (ready),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a divide from a negedge; return at the negedge of the valid cycle.
    // poke > 0 re-asserts start (with other operands) so it is sampled at
    // edge `poke` while the divider is busy.
    task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic sg, input logic [63:0] exp_q,
                           input logic [63:0] exp_r, input int exp_lat, input int poke);
        int           lat;
        logic         busy_ok;
        logic         hold_ok;
        logic [63:0]  q0;
        logic [63:0]  r0;
        q0        = quotient;
        r0        = remainder;
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat      = 0;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        while (lat < 200) begin
            @(negedge clock);
            lat++;
            if (valid) break;
            if (ready) busy_ok = 1'b0;
            if (quotient !== q0 || remainder !== r0) hold_ok = 1'b0;
            start = (lat == poke - 1);
            if (start) begin
                dividend = 64'd7;
                divisor  = 64'd1;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"},    {63'd0, busy_ok}, 64'd1);
        check({tag, "_hold"},    {63'd0, hold_ok}, 64'd1);
        check({tag, "_ready"},   {63'd0, ready}, 64'd1);
        check({tag, "_quo"},     quotient, exp_q);
        check({tag, "_rem"},     remainder, exp_r);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        check({tag, "_vpulse"}, {63'd0, valid}, 64'd0);
        check({tag, "_idle"},   {63'd0, ready}, 64'd1);
    endtask

    task automatic no_valid_window(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (valid) seen = 1'b1;
        end
        check({tag, "_novalid"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_quo",   quotient, 64'd0);
        check("rst_rem",   remainder, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_div("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66, 0);
        idle_check("u100_7");

        // Second divide starts on the valid cycle of the first.
        run_div("sm7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        run_div("s7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0);
        idle_check("s7_m2");

        run_div("u5_0", 64'd5, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2, 0);
        idle_check("u5_0");
        run_div("s5_0", 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2, 0);
        idle_check("s5_0");

        run_div("smin_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'h8000_0000_0000_0000, 64'd0, 2, 0);
        idle_check("smin_m1");
        run_div("umin_max", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'd0, 64'h8000_0000_0000_0000, 66, 0);
        idle_check("umin_max");

        run_div("umax_3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0,
                64'h5555_5555_5555_5555, 64'd0, 66, 0);
        run_div("sm100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        idle_check("sm100_7");

        // start pulsed at edge 10 while busy must be ignored, not queued.
        run_div("poke", 64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 66, 10);
        idle_check("poke");

        // Reset sampled mid-RUN aborts the divide and clears the results.
        dividend  = 64'd100;
        divisor   = 64'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (30) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("rrst_ready", {63'd0, ready}, 64'd1);
        check("rrst_valid", {63'd0, valid}, 64'd0);
        check("rrst_quo",   quotient, 64'd0);
        check("rrst_rem",   remainder, 64'd0);
        reset_n = 1'b1;
        no_valid_window("rrst", 80);
        check("rrst_quo_after", quotient, 64'd0);

`ifdef DIVIDER_FLUSH_EN
        run_div("pre_flush", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66, 0);
        idle_check("pre_flush");
        dividend = 64'd1000;
        divisor  = 64'd10;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (30) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_ready", {63'd0, ready}, 64'd1);
        check("flush_valid", {63'd0, valid}, 64'd0);
        check("flush_quo",   quotient, 64'd14);
        check("flush_rem",   remainder, 64'd2);
        no_valid_window("flush", 80);

        // flush together with start in IDLE drops the start.
        dividend = 64'd9;
        divisor  = 64'd3;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_ready", {63'd0, ready}, 64'd1);
        no_valid_window("flush_start", 80);
        check("flush_start_quo", quotient, 64'd14);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
